mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store front end between the CPU memory stage and the word-only data memory. It accepts byte, halfword and word accesses from the pipeline and handles the rest internally: lane selection, sign/zero extension and alignment checking. Sub-word stores become a read-modify-write on the memory's word port. The memory side has a combinational read and a clocked write, both word-aligned.

## Interface
Parameters:
- `ADDR_W`, 32: address width on both sides.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req`  in  1  access request; accepted on a rising edge when `req && ready`.
- `we`  in  1  1 = store, 0 = load.
- `size`  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
- `sign_ext`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `addr`  in  ADDR_W  byte address.
- `wdata`  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- `ready`  out  1  unit can accept a request this cycle.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  32  load result; valid while `done`=1; held until the next `done`.
- `err`  out  1  misaligned access; valid with `done`.
- `mem_rd`  out  1  memory read enable.
- `mem_wr`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  word-aligned address: `{addr[ADDR_W-1:2],2'b00}`.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data, combinational from `mem_addr`.

## Operation
- Byte lanes are little-endian: offset 0 is bits [7:0] and offset 3 is bits [31:24]. A halfword at offset 0 is [15:0]; at offset 2 it is [31:16].
- Misaligned means:
  - halfword with `addr[0]`=1;
  - word with `addr[1:0]`!=0.
  - A misaligned access drives no memory enable. It completes with `done`=1, `err`=1 and `rdata`=0.
- The unit does no address-region decoding. All addresses, peripheral region (`addr[31:28]`=4'h4) included, are passed to the memory port unchanged.

States: IDLE, MERGE, DONE.
- IDLE (`ready`=1). On an accepted request:
  - Load, aligned: `mem_rd`=1 this cycle. Extract the lane from `mem_rdata` and extend it into `rdata`. Go to DONE.
  - Word store, aligned: `mem_wr`=1 and `mem_wdata`=`wdata` this cycle. Go to DONE.
  - Byte or halfword store, aligned: `mem_rd`=1 this cycle. Latch `mem_rdata`, the offset, `size` and `wdata`. Go to MERGE.
  - Misaligned: no memory enable; latch `err`. Go to DONE.
- MERGE (`ready`=0): `mem_wr`=1. `mem_wdata` is the latched word with the target lane(s) replaced by `wdata[7:0]` or `wdata[15:0]`. Go to DONE.
- DONE (`ready`=1): `done`=1 for this cycle only. An accepted request here is handled exactly as from IDLE. Without a request, go to IDLE.
- Word-store `rdata`: `rdata` and `err` update only when a load completes or when a misaligned access is flagged. A word store leaves `rdata` unchanged.
- Sub-word-store `rdata`: same rule as word stores; `rdata` keeps its previous value.
- `mem_rd` and `mem_wr` are never both 1 in the same cycle.

## Timing
- Reset (`reset`=0 at a rising edge):
  - state is IDLE;
  - `done`=0, `err`=0, `rdata`=0;
  - the merge register is cleared.
- While `reset`=0, `mem_rd`, `mem_wr` and `ready` are forced to 0 combinationally.
- Reset in MERGE aborts the store: no write is issued and the memory word is unchanged.
- Latency, counted from the acceptance cycle (cycle 0):
  - load, word store, misaligned: `done` in cycle 1;
  - sub-word store: `done` in cycle 2.
- `mem_addr`, `mem_rd` and `mem_wr` (IDLE/DONE) are combinational from `req`, `addr`, `we` and `size` in the acceptance cycle.
- Back-to-back requests are accepted every cycle for loads and word stores. A sub-word store blocks for one extra cycle (MERGE).
- Read-after-write: a load accepted the cycle after a store's write edge sees the stored data. No bypass is needed.
- `req` held while `ready`=0 is not accepted. The requester keeps its inputs stable until acceptance.

## Test plan
- Word store then word load:
  - stimulus: store 0xDEADBEEF at 0x10, then load word 0x10;
  - response: one `mem_wr` pulse with `mem_addr`=0x10; `done` in cycle 1 of each op; `rdata`=0xDEADBEEF.
- Byte store read-modify-write:
  - stimulus: memory word 0x10 = 0x11223344; store byte 0xAB at 0x12;
  - response: `mem_rd` in cycle 0; `mem_wr` in cycle 1 with `mem_wdata`=0x11AB3344; `ready`=0 in cycle 1; `done` in cycle 2.
- Sign/zero extension (word 0x10 = 0x8001F0FF):
  - lb 0x10 -> 0xFFFFFFFF;
  - lbu 0x10 -> 0x000000FF;
  - lh 0x12 -> 0xFFFF8001;
  - lhu 0x12 -> 0x00008001.
- Misaligned accesses:
  - stimulus: lh 0x13, then sw 0x11;
  - response: no `mem_rd`/`mem_wr`; `done`=1 and `err`=1 in cycle 1; `rdata`=0; memory unchanged.
- Back-to-back traffic:
  - stimulus: `req` held with lw 0x0, lw 0x4, sh 0x8, lw 0x8;
  - response: accepts in cycles 0, 1, 2 and 4; halfword merge visible to the final load.
- Reset mid-operation:
  - stimulus: `reset`=0 during MERGE of sb 0x20 with 0x55;
  - response: no write; word 0x20 unchanged; all outputs at reset values; next request completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store front end for a word-only data memory: lane select, sign/zero extension,
// alignment checking and read-modify-write for sub-word stores.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        dbg_state
);

    // Handshake: a request is taken on a rising edge when req && ready; the requester
    // holds its inputs stable until then. done pulses for exactly one cycle per request.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MERGE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       merge_word_q, merge_word_d;
    logic [15:0]       merge_data_q, merge_data_d;
    logic [1:0]        merge_off_q, merge_off_d;
    logic              merge_half_q, merge_half_d;
    logic [ADDR_W-1:2] merge_addr_q, merge_addr_d;

    logic        in_service;
    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic [31:0] shifted;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_val;
    logic [31:0] merged;

    always_comb begin
        in_service = (state_q != ST_MERGE);
        is_half    = (size == 2'b01);
        is_word    = size[1];
        misaligned = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));

        shifted   = mem_rdata >> {addr[1:0], 3'b000};
        byte_lane = shifted[7:0];
        half_lane = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size)
            2'b00:   load_val = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            2'b01:   load_val = {{16{sign_ext & half_lane[15]}}, half_lane};
            default: load_val = mem_rdata;
        endcase

        merged = merge_word_q;
        if (merge_half_q) begin
            if (merge_off_q[1]) merged[31:16] = merge_data_q;
            else                merged[15:0]  = merge_data_q;
        end else begin
            merged[{merge_off_q, 3'b000} +: 8] = merge_data_q[7:0];
        end
    end

    // Memory enables are gated by reset so a store caught in MERGE never lands.
    always_comb begin
        ready     = reset && in_service;
        mem_rd    = ready && req && !misaligned && (!we || !is_word);
        mem_wr    = reset && ((state_q == ST_MERGE) ||
                              (req && in_service && we && is_word && !misaligned));
        mem_addr  = (state_q == ST_MERGE) ? {merge_addr_q, 2'b00}
                                          : {addr[ADDR_W-1:2], 2'b00};
        mem_wdata = (state_q == ST_MERGE) ? merged : wdata;
        done      = done_q;
        err       = err_q;
        rdata     = rdata_q;
        dbg_state = state_q;
    end

    always_comb begin
        state_d      = state_q;
        done_d       = 1'b0;
        err_d        = err_q;
        rdata_d      = rdata_q;
        merge_word_d = merge_word_q;
        merge_data_d = merge_data_q;
        merge_off_d  = merge_off_q;
        merge_half_d = merge_half_q;
        merge_addr_d = merge_addr_q;
        case (state_q)
            ST_MERGE: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            default: begin
                if (req) begin
                    if (misaligned) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (!we) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b0;
                        rdata_d = load_val;
                    end else if (is_word) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d      = ST_MERGE;
                        merge_word_d = mem_rdata;
                        merge_data_d = wdata[15:0];
                        merge_off_d  = addr[1:0];
                        merge_half_d = is_half;
                        merge_addr_d = addr[ADDR_W-1:2];
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            merge_word_q <= '0;
            merge_data_q <= '0;
            merge_off_q  <= '0;
            merge_half_q <= 1'b0;
            merge_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            merge_word_q <= merge_word_d;
            merge_data_q <= merge_data_d;
            merge_off_q  <= merge_off_d;
            merge_half_q <= merge_half_d;
            merge_addr_q <= merge_addr_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word memory model on the memory port, byte-array
// reference of the architectural memory, directed scenarios and random traffic.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ready, done, err, mem_rd, mem_wr;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  dbg_state;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .ready(ready),
        .done(done), .rdata(rdata), .err(err), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    // Word memory on the DUT's port: combinational read, clocked write.
    logic [31:0] mem_words [0:255];
    assign mem_rdata = mem_words[mem_addr[9:2]];
    always @(posedge clk) if (mem_wr) mem_words[mem_addr[9:2]] <= mem_wdata;

    // Reference: memory as plain bytes, little-endian.
    logic [7:0]  ref_bytes [0:1023];
    logic [31:0] model_rdata = '0;
    logic        model_err = 1'b0;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
    } op_t;
    op_t ops[$];

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int n, input logic sext);
        logic [31:0] v;
        int base;
        v = '0;
        base = int'(a[9:0]);
        for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[base + i]) << (8 * i));
        if (sext && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] d);
        int base;
        base = int'(a[9:0]);
        for (int i = 0; i < n; i++) ref_bytes[base + i] = 8'(d >> (8 * i));
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return ref_load({a[31:2], 2'b00}, 4, 1'b0);
    endfunction

    task automatic push_op(input logic w, input logic [1:0] s, input logic sx,
                           input logic [31:0] a, input logic [31:0] d);
        op_t o;
        o.we = w; o.size = s; o.sext = sx; o.addr = a; o.wdata = d;
        ops.push_back(o);
    endtask

    // Drains the op queue, presenting ops with random idle gaps and checking every cycle.
    task automatic run_stream(input int gap_pct);
        int    cyc;
        bit    sched_done, sched_merge, cur_done, cur_merge, present, pend_upd, mis;
        logic [31:0] pend_rdata, merge_exp, merge_addr_exp;
        logic  pend_err, exp_rd, exp_wr;
        int    n;
        op_t   o;
        cyc = 0; sched_done = 0; sched_merge = 0; pend_upd = 0;
        pend_rdata = '0; pend_err = 1'b0; merge_exp = '0; merge_addr_exp = '0;
        while ((ops.size() > 0 || sched_done || sched_merge) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            cur_done = sched_done; cur_merge = sched_merge;
            sched_done = 0; sched_merge = 0;
            if (cur_merge) sched_done = 1;
            if (cur_done && pend_upd) begin
                model_rdata = pend_rdata;
                model_err   = pend_err;
            end
            present = (ops.size() > 0) && ($urandom_range(0, 99) >= gap_pct);
            if (present) begin
                o = ops[0];
                req = 1'b1; we = o.we; size = o.size; sign_ext = o.sext;
                addr = o.addr; wdata = o.wdata;
            end else begin
                req = 1'b0;
            end
            #1;
            n_vec++;
            if (done !== cur_done) begin
                n_fail++; $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, cur_done);
            end
            n_vec++;
            if (ready !== !cur_merge) begin
                n_fail++; $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, ready, !cur_merge);
            end
            n_vec++;
            if (rdata !== model_rdata) begin
                n_fail++; $display("FAIL rdata cyc=%0d got=%h exp=%h", cyc, rdata, model_rdata);
            end
            if (cur_done && pend_upd) begin
                n_vec++;
                if (err !== model_err) begin
                    n_fail++; $display("FAIL err cyc=%0d got=%b exp=%b", cyc, err, model_err);
                end
            end
            if (cur_merge) begin
                n_vec++;
                if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== merge_addr_exp ||
                    mem_wdata !== merge_exp) begin
                    n_fail++;
                    $display("FAIL merge_write cyc=%0d got wr=%b rd=%b a=%h d=%h exp a=%h d=%h",
                             cyc, mem_wr, mem_rd, mem_addr, mem_wdata, merge_addr_exp, merge_exp);
                end
            end else if (present) begin
                n = nbytes(o.size);
                mis = (int'(o.addr[9:0]) % n) != 0;
                exp_rd = !mis && (!o.we || n < 4);
                exp_wr = !mis && o.we && n == 4;
                n_vec++;
                if (mem_rd !== exp_rd || mem_wr !== exp_wr || mem_addr !== {o.addr[31:2], 2'b00}) begin
                    n_fail++;
                    $display("FAIL accept_port cyc=%0d got rd=%b wr=%b a=%h exp rd=%b wr=%b a=%h",
                             cyc, mem_rd, mem_wr, mem_addr, exp_rd, exp_wr, {o.addr[31:2], 2'b00});
                end
                if (exp_wr) begin
                    n_vec++;
                    if (mem_wdata !== o.wdata) begin
                        n_fail++; $display("FAIL word_wdata cyc=%0d got=%h exp=%h", cyc, mem_wdata, o.wdata);
                    end
                end
                pend_upd = mis || !o.we;
                if (mis) begin
                    pend_rdata = '0; pend_err = 1'b1; sched_done = 1;
                end else if (!o.we) begin
                    pend_rdata = ref_load(o.addr, n, o.sext); pend_err = 1'b0; sched_done = 1;
                end else if (n == 4) begin
                    ref_store(o.addr, n, o.wdata); sched_done = 1;
                end else begin
                    ref_store(o.addr, n, o.wdata);
                    merge_exp = ref_word(o.addr);
                    merge_addr_exp = {o.addr[31:2], 2'b00};
                    sched_merge = 1;
                end
                void'(ops.pop_front());
            end else begin
                n_vec++;
                if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
                    n_fail++; $display("FAIL idle_port cyc=%0d got rd=%b wr=%b exp 0 0", cyc, mem_rd, mem_wr);
                end
            end
        end
        if (ops.size() > 0 || sched_done || sched_merge) begin
            n_vec++; n_fail++;
            $display("FAIL stream_timeout cyc=%0d got %0d ops left exp 0", cyc, ops.size());
            ops.delete();
        end
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h10; wdata = 32'h1234_5678;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (ready !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
            n_fail++; $display("FAIL reset_enables got ready=%b rd=%b wr=%b exp 0 0 0", ready, mem_rd, mem_wr);
        end
        n_vec++;
        if (done !== 1'b0 || err !== 1'b0 || rdata !== 32'h0 || dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL reset_outputs got done=%b err=%b rdata=%h st=%0d exp 0 0 0 0",
                               done, err, rdata, dbg_state);
        end
        req = 1'b0;
        reset = 1'b1;
        model_rdata = '0; model_err = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 256; i++) push_op(1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom);
        run_stream(0);
    endtask

    task automatic test_word_store_load();
        push_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        push_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        run_stream(0);
        n_vec++;
        if (rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL sw_lw got=%h exp=deadbeef", rdata);
        end
    endtask

    task automatic test_byte_rmw();
        push_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344);
        push_op(1'b1, 2'b00, 1'b0, 32'h12, 32'h7654_32AB);
        push_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        run_stream(0);
        n_vec++;
        if (rdata !== 32'h11AB_3344) begin
            n_fail++; $display("FAIL sb_rmw got=%h exp=11ab3344", rdata);
        end
    endtask

    task automatic test_sign_ext();
        logic [1:0]  sz [4]  = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        sx [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] ad [4]  = '{32'h10, 32'h10, 32'h12, 32'h12};
        logic [31:0] ex [4]  = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_8001, 32'h0000_8001};
        push_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h8001_F0FF);
        run_stream(0);
        for (int i = 0; i < 4; i++) begin
            push_op(1'b0, sz[i], sx[i], ad[i], 32'h0);
            run_stream(0);
            n_vec++;
            if (rdata !== ex[i]) begin
                n_fail++; $display("FAIL ext_load%0d got=%h exp=%h", i, rdata, ex[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        push_op(1'b0, 2'b01, 1'b1, 32'h13, 32'h0);
        push_op(1'b1, 2'b10, 1'b0, 32'h11, 32'hCAFE_F00D);
        run_stream(0);
        n_vec++;
        if (rdata !== 32'h0 || err !== 1'b1) begin
            n_fail++; $display("FAIL misaligned got rdata=%h err=%b exp 0 1", rdata, err);
        end
        push_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        run_stream(0);
        n_vec++;
        if (rdata !== 32'h8001_F0FF || err !== 1'b0) begin
            n_fail++; $display("FAIL misaligned_mem got rdata=%h err=%b exp 8001f0ff 0", rdata, err);
        end
    endtask

    task automatic test_back_to_back();
        push_op(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        push_op(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        push_op(1'b1, 2'b01, 1'b0, 32'h8, 32'hABCD_BEEF);
        push_op(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        run_stream(0);
        n_vec++;
        if (rdata[15:0] !== 16'hBEEF) begin
            n_fail++; $display("FAIL b2b_half got=%h exp=beef", rdata[15:0]);
        end
    endtask

    task automatic test_peripheral();
        push_op(1'b1, 2'b10, 1'b0, 32'h4000_0020, 32'h0BAD_F00D);
        push_op(1'b0, 2'b01, 1'b0, 32'h4000_0022, 32'h0);
        run_stream(0);
        n_vec++;
        if (rdata !== 32'h0000_0BAD) begin
            n_fail++; $display("FAIL peripheral got=%h exp=00000bad", rdata);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [1:0]  s;
        for (int i = 0; i < 300; i++) begin
            s = 2'($urandom_range(0, 3));
            a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 9) < 7) a = a & ~32'(nbytes(s) - 1);
            push_op(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom);
        end
        run_stream(30);
    endtask

    task automatic test_reset_merge();
        push_op(1'b1, 2'b10, 1'b0, 32'h20, 32'h9988_7766);
        run_stream(0);
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'h20; wdata = 32'h55;
        #1;
        n_vec++;
        if (mem_rd !== 1'b1 || ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_merge_accept got rd=%b ready=%b exp 1 1", mem_rd, ready);
        end
        @(negedge clk);
        req = 1'b0;
        #1;
        n_vec++;
        if (mem_wr !== 1'b1) begin
            n_fail++; $display("FAIL rst_merge_pending got wr=%b exp 1", mem_wr);
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if (mem_wr !== 1'b0 || mem_rd !== 1'b0 || ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_merge_gate got wr=%b rd=%b ready=%b exp 0 0 0", mem_wr, mem_rd, ready);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_vec++;
        if (done !== 1'b0 || err !== 1'b0 || rdata !== 32'h0 || ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_merge_outputs got done=%b err=%b rdata=%h ready=%b exp 0 0 0 1",
                               done, err, rdata, ready);
        end
        model_rdata = '0; model_err = 1'b0;
        push_op(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        run_stream(0);
        n_vec++;
        if (rdata !== 32'h9988_7766) begin
            n_fail++; $display("FAIL rst_merge_mem got=%h exp=99887766", rdata);
        end
    endtask

    task automatic test_final_memory();
        for (int i = 0; i < 256; i++) begin
            n_vec++;
            if (mem_words[i] !== ref_word(32'(i * 4))) begin
                n_fail++; $display("FAIL mem_word%0d got=%h exp=%h", i, mem_words[i], ref_word(32'(i * 4)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_word_store_load();
        test_byte_rmw();
        test_sign_ext();
        test_misaligned();
        test_back_to_back();
        test_peripheral();
        test_random();
        test_reset_merge();
        test_final_memory();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
